game_status_controller: RTL and testbench
=========================================

GAME_STATUS_CONTROLLER -- requirements
Module: game_status_controller

Interface
REQ-001 SHALL have parameter MAX_TURNS, default 20, meaning shots allowed per game (legal range 1..31).
REQ-002 SHALL have parameter SHIP_CELLS, default 9, meaning total ship cells that must be hit to win (legal range 1..31).
REQ-003 SHALL have parameter FLASH_CYCLES, default 50_000_000, meaning result-display hold time per shot, in clk cycles (legal minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to begin a new game.
REQ-007 SHALL have port shot_valid, input, 1 bit: a shot result is offered.
REQ-008 SHALL have port shot_hit, input, 1 bit: the offered shot struck a ship cell.
REQ-009 SHALL have port shot_repeat, input, 1 bit: the offered shot targets a cell that was already fired on.
REQ-010 SHALL have port shot_ready, output, 1 bit: the controller accepts a shot this cycle.
REQ-011 SHALL have port turns_left, output, 5 bits: remaining shots, drives the display controller.
REQ-012 SHALL have port hits, output, 5 bits: ship cells hit so far.
REQ-013 SHALL have port hit_flash, output, 1 bit: high while the display shows a hit result.
REQ-014 SHALL have port win, output, 1 bit: game won; drives the display controller.
REQ-015 SHALL have port lose, output, 1 bit: game lost; drives the display controller.
REQ-016 SHALL have port busy, output, 1 bit: a game is in progress (state PLAY or SHOW).

Function
REQ-017 SHALL implement the states IDLE, PLAY, SHOW, WIN and LOSE.
REQ-018 IDLE, WIN and LOSE: start=1 SHALL load turns_left=MAX_TURNS and hits=0, clear win and lose, and enter PLAY on the next edge.
REQ-019 PLAY and SHOW: start SHALL be ignored.
REQ-020 shot_ready SHALL be 1 only in PLAY.
REQ-021 A shot is accepted when shot_valid & shot_ready; shot_valid outside PLAY SHALL be ignored and SHALL leave no side effects.
REQ-022 On an accepted shot with shot_repeat=0: turns_left SHALL decrement by 1, and if shot_hit=1 hits SHALL increment by 1, both in the acceptance cycle's edge.
REQ-023 On an accepted shot with shot_repeat=1: turns_left and hits SHALL be unchanged, and shot_hit SHALL be disregarded.
REQ-024 Every accepted shot SHALL enter SHOW, loading the flash counter with FLASH_CYCLES-1.
REQ-025 In SHOW, hit_flash SHALL equal the registered (shot_hit & ~shot_repeat) of the accepted shot; hit_flash SHALL be 0 in all other states.
REQ-026 SHOW SHALL last exactly FLASH_CYCLES cycles, after which the controller evaluates in the last SHOW cycle and moves on the next edge:
- hits==SHIP_CELLS -> WIN;
- else turns_left==0 -> LOSE;
- else -> PLAY.
REQ-027 If the final turn also completes the ships, the result SHALL be WIN, because win has priority over lose.
REQ-028 win SHALL be 1 only in WIN, and lose SHALL be 1 only in LOSE; both SHALL be registered outputs, never both 1.
REQ-029 hits SHALL saturate at SHIP_CELLS, and turns_left SHALL saturate at 0; neither SHALL wrap.
REQ-030 Latency from the acceptance edge to the game-over flag rising SHALL be FLASH_CYCLES+1 edges.
REQ-031 turns_left and hits SHALL hold their final values in WIN and LOSE until the next start.

Reset
REQ-032 While rst_n=0, the controller SHALL immediately go to IDLE with turns_left=MAX_TURNS, hits=0, shot_ready=0, hit_flash=0, win=0, lose=0, busy=0, and flash counter=0.
REQ-033 Reset asserted mid-SHOW or mid-PLAY SHALL abort the game; after release, the controller SHALL wait in IDLE for start.

Structure
REQ-034 A shared package battleship_pkg SHALL hold:
- the state enum;
- TURN_W=5 and HIT_W=5;
- default MAX_TURNS and SHIP_CELLS constants.
REQ-035 The flash countdown SHALL be a sub-module, flash_timer, with the following interface:
- inputs: load and a load value;
- outputs: an expire pulse and a running flag;
- width: $clog2(FLASH_CYCLES).
REQ-036 The whole design SHALL run in the single clk domain, with no combinational path from shot_* inputs to win or lose.

Verification (FLASH_CYCLES=4, MAX_TURNS=3, SHIP_CELLS=2 in bench)
REQ-037 Reset then start, 3 misses -> turns_left 3->2->1->0, hits=0, lose=1 exactly 5 edges after the third acceptance, win=0.
REQ-038 Start, hit, miss, hit -> hits=2, turns_left=0, win=1, lose=0 (win priority).
REQ-039 Start, then a repeat shot with shot_hit=1 -> turns_left stays 3, hits stays 0, hit_flash=0, SHOW lasts 4 cycles, then PLAY.
REQ-040 shot_valid held high through SHOW -> only 1 acceptance; shot_ready=0 for 4 cycles, then a second acceptance.
REQ-041 start pulsed during PLAY and SHOW -> ignored; start pulsed in WIN -> turns_left=3, hits=0, win=0, PLAY next edge.
REQ-042 rst_n dropped mid-SHOW -> outputs reset asynchronously before the next edge; IDLE after release.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared definitions for the battleship game controller slice.
// Holds the game state encoding, the counter widths used by the display
// path, the default game parameters and a helper that sizes the flash
// countdown.
`timescale 1ns/1ps
package battleship_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAY,
      ST_SHOW,
      ST_WIN,
      ST_LOSE
   } game_state_t;

   localparam int TURN_W         = 5;
   localparam int HIT_W          = 5;
   localparam int DEF_MAX_TURNS  = 20;
   localparam int DEF_SHIP_CELLS = 9;

   // A one-cycle hold still needs a one-bit counter.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/flash_timer.sv
// Result-display hold timer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - restart the countdown from load_val
//   load_val    - cycles to count minus one
//   expire      - high during the final counted cycle
//   running     - countdown in progress
`timescale 1ns/1ps
module flash_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire,
   output logic         running
);

   logic [W-1:0] cnt;

   // Running for load_val+1 cycles; expire marks the last of them.
   assign expire = running && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         running <= 1'b0;
      end else if (load) begin
         cnt     <= load_val;
         running <= 1'b1;
      end else if (running) begin
         if (cnt == '0) begin
            running <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/game_status_controller.sv
// Battleship game status controller: counts turns and hits, holds each
// shot result on the display for FLASH_CYCLES cycles, then decides between
// continuing play, win and lose.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   start                          - begin a new game (IDLE/WIN/LOSE only)
//   shot_valid/hit/repeat          - shot result offer from the board logic
//   shot_ready                     - shot accepted this cycle (PLAY only)
//   turns_left, hits               - game counters for the display
//   hit_flash                      - showing a fresh hit
//   win, lose                      - registered game-over flags
//   busy                           - game in progress (PLAY or SHOW)
`timescale 1ns/1ps
module game_status_controller
   import battleship_pkg::*;
#(
   parameter int MAX_TURNS    = DEF_MAX_TURNS,
   parameter int SHIP_CELLS   = DEF_SHIP_CELLS,
   parameter int FLASH_CYCLES = 50_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              shot_valid,
   input  logic              shot_hit,
   input  logic              shot_repeat,
   output logic              shot_ready,
   output logic [TURN_W-1:0] turns_left,
   output logic [HIT_W-1:0]  hits,
   output logic              hit_flash,
   output logic              win,
   output logic              lose,
   output logic              busy
);

   localparam int                CNT_W      = cnt_width(FLASH_CYCLES);
   localparam logic [CNT_W-1:0]  FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
   localparam logic [TURN_W-1:0] TURNS_INIT = TURN_W'(MAX_TURNS);
   localparam logic [HIT_W-1:0]  HITS_GOAL  = HIT_W'(SHIP_CELLS);

   game_state_t state, state_nxt;
   logic        accept;
   logic        new_game;
   logic        timer_expire;
   logic        timer_running;

   flash_timer #(
      .W (CNT_W)
   ) u_flash_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (FLASH_LOAD),
      .expire   (timer_expire),
      .running  (timer_running)
   );

   assign shot_ready = (state == ST_PLAY);
   assign busy       = (state == ST_PLAY) || (state == ST_SHOW);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      new_game  = 1'b0;
      case (state)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (start) begin
               state_nxt = ST_PLAY;
               new_game  = 1'b1;
            end
         end
         ST_PLAY: begin
            if (shot_valid) begin
               accept    = 1'b1;
               state_nxt = ST_SHOW;
            end
         end
         ST_SHOW: begin
            // Counters were updated at acceptance, so they are final here;
            // checking hits first gives a last-turn sinking the win.
            if (timer_expire) begin
               if (hits == HITS_GOAL) begin
                  state_nxt = ST_WIN;
               end else if (turns_left == '0) begin
                  state_nxt = ST_LOSE;
               end else begin
                  state_nxt = ST_PLAY;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         turns_left <= TURNS_INIT;
         hits       <= '0;
         hit_flash  <= 1'b0;
         win        <= 1'b0;
         lose       <= 1'b0;
      end else begin
         state <= state_nxt;
         win   <= (state_nxt == ST_WIN);
         lose  <= (state_nxt == ST_LOSE);

         if (new_game) begin
            turns_left <= TURNS_INIT;
            hits       <= '0;
         end else if (accept && !shot_repeat) begin
            if (turns_left != '0) begin
               turns_left <= turns_left - 1'b1;
            end
            if (shot_hit && (hits < HITS_GOAL)) begin
               hits <= hits + 1'b1;
            end
         end

         if (accept) begin
            hit_flash <= shot_hit && !shot_repeat;
         end else if (state_nxt != ST_SHOW) begin
            hit_flash <= 1'b0;
         end
      end
   end

   // Timer running flag mirrors SHOW; kept for observability only.
   logic unused_ok;
   assign unused_ok = timer_running;

endmodule

// File: tb/tb_game_status_controller.sv
`timescale 1ns/1ps
module tb_game_status_controller;

   localparam int F = 4;
   localparam int M = 3;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       shot_valid;
   logic       shot_hit;
   logic       shot_repeat;
   logic       shot_ready;
   logic [4:0] turns_left;
   logic [4:0] hits;
   logic       hit_flash;
   logic       win;
   logic       lose;
   logic       busy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   game_status_controller #(
      .MAX_TURNS    (M),
      .SHIP_CELLS   (S),
      .FLASH_CYCLES (F)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .shot_valid  (shot_valid),
      .shot_hit    (shot_hit),
      .shot_repeat (shot_repeat),
      .shot_ready  (shot_ready),
      .turns_left  (turns_left),
      .hits        (hits),
      .hit_flash   (hit_flash),
      .win         (win),
      .lose        (lose),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_ready", {31'd0, shot_ready}, 1);
      check("start_turns", {27'd0, turns_left}, M);
      check("start_hits",  {27'd0, hits}, 0);
      check("start_win",   {31'd0, win}, 0);
      check("start_lose",  {31'd0, lose}, 0);
   endtask

   // Offer one shot in PLAY; expected counters/flash after the acceptance edge.
   task automatic fire(input logic hit, input logic rep,
                       input int et, input int eh, input int ef);
      shot_valid  = 1'b1;
      shot_hit    = hit;
      shot_repeat = rep;
      check("fire_ready_before", {31'd0, shot_ready}, 1);
      step();
      shot_valid  = 1'b0;
      shot_hit    = 1'b0;
      shot_repeat = 1'b0;
      check("fire_turns", {27'd0, turns_left}, et);
      check("fire_hits",  {27'd0, hits}, eh);
      check("fire_flash", {31'd0, hit_flash}, ef);
      check("fire_ready_after", {31'd0, shot_ready}, 0);
      check("fire_busy", {31'd0, busy}, 1);
   endtask

   // Remaining SHOW cycles then the decision edge.
   // outcome: 0 back to PLAY, 1 WIN, 2 LOSE.
   task automatic ride_show(input int outcome, input bit pulse_start);
      for (int k = 0; k < F - 1; k++) begin
         start = pulse_start && (k == 0);
         step();
         start = 1'b0;
         check("show_ready", {31'd0, shot_ready}, 0);
         check("show_busy",  {31'd0, busy}, 1);
         check("show_win",   {31'd0, win}, 0);
         check("show_lose",  {31'd0, lose}, 0);
      end
      step();
      check("end_ready", {31'd0, shot_ready}, (outcome == 0) ? 1 : 0);
      check("end_win",   {31'd0, win},  (outcome == 1) ? 1 : 0);
      check("end_lose",  {31'd0, lose}, (outcome == 2) ? 1 : 0);
      check("end_busy",  {31'd0, busy}, (outcome == 0) ? 1 : 0);
      check("end_flash", {31'd0, hit_flash}, 0);
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      shot_valid  = 1'b0;
      shot_hit    = 1'b0;
      shot_repeat = 1'b0;
      #12;
      check("rst_turns", {27'd0, turns_left}, M);
      check("rst_hits",  {27'd0, hits}, 0);
      check("rst_ready", {31'd0, shot_ready}, 0);
      check("rst_flash", {31'd0, hit_flash}, 0);
      check("rst_win",   {31'd0, win}, 0);
      check("rst_lose",  {31'd0, lose}, 0);
      check("rst_busy",  {31'd0, busy}, 0);
      rst_n = 1'b1;
      step();
      // shot_valid in IDLE has no effect
      shot_valid = 1'b1;
      shot_hit   = 1'b1;
      step();
      shot_valid = 1'b0;
      shot_hit   = 1'b0;
      check("idle_ready", {31'd0, shot_ready}, 0);
      check("idle_hits",  {27'd0, hits}, 0);
      check("idle_turns", {27'd0, turns_left}, M);

      // Three misses -> LOSE
      do_start();
      fire(1'b0, 1'b0, 2, 0, 0); ride_show(0, 1'b0);
      fire(1'b0, 1'b0, 1, 0, 0); ride_show(0, 1'b0);
      fire(1'b0, 1'b0, 0, 0, 0); ride_show(2, 1'b0);
      check("lose_turns_hold", {27'd0, turns_left}, 0);
      step();
      check("lose_hold", {31'd0, lose}, 1);

      // Hit, miss, hit -> WIN on final turn; start ignored in SHOW and PLAY
      do_start();
      fire(1'b1, 1'b0, 2, 1, 1); ride_show(0, 1'b1);
      check("show_start_turns", {27'd0, turns_left}, 2);
      check("show_start_hits",  {27'd0, hits}, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      check("play_start_turns", {27'd0, turns_left}, 2);
      check("play_start_ready", {31'd0, shot_ready}, 1);
      fire(1'b0, 1'b0, 1, 1, 0); ride_show(0, 1'b0);
      fire(1'b1, 1'b0, 0, 2, 1); ride_show(1, 1'b0);
      check("win_hits",  {27'd0, hits}, 2);
      check("win_turns", {27'd0, turns_left}, 0);

      // Start from WIN
      do_start();

      // Repeat shot with hit set: nothing counted, no flash
      fire(1'b1, 1'b1, 3, 0, 0); ride_show(0, 1'b0);

      // shot_valid held through SHOW: one acceptance, then another
      shot_valid = 1'b1;
      step();
      check("hold_turns_a", {27'd0, turns_left}, 2);
      for (int k = 0; k < F - 1; k++) begin
         step();
         check("hold_ready", {31'd0, shot_ready}, 0);
         check("hold_turns", {27'd0, turns_left}, 2);
      end
      step();
      check("hold_ready_back", {31'd0, shot_ready}, 1);
      check("hold_turns_b", {27'd0, turns_left}, 2);
      step();
      shot_valid = 1'b0;
      check("hold_turns_c", {27'd0, turns_left}, 1);
      check("hold_ready_c", {31'd0, shot_ready}, 0);
      ride_show(0, 1'b0);

      // Reset mid-SHOW
      fire(1'b1, 1'b0, 0, 1, 1);
      step();
      check("pre_rst_flash", {31'd0, hit_flash}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_turns", {27'd0, turns_left}, M);
      check("arst_hits",  {27'd0, hits}, 0);
      check("arst_flash", {31'd0, hit_flash}, 0);
      check("arst_busy",  {31'd0, busy}, 0);
      check("arst_ready", {31'd0, shot_ready}, 0);
      #2 rst_n = 1'b1;
      step();
      step();
      check("post_rst_ready", {31'd0, shot_ready}, 0);
      check("post_rst_busy",  {31'd0, busy}, 0);
      do_start();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
